// File: rtl/fp16_pkg.sv
// FP16 field layout, classification type and shared constants for the FP16 to
// fixed-point converter.
package fp16_pkg;

  localparam int EXP_W    = 5;
  localparam int MAN_W    = 10;
  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX  = 31;
  localparam int SIG_W    = MAN_W + 1;
  localparam int SHIFT_W  = 7;

  typedef enum logic [2:0] {
    ZERO,
    SUBNORM,
    NORMAL,
    INF,
    NAN
  } fp16_class_t;

endpackage

// File: rtl/fp16_to_fixed_pipe_if.sv
// Input/output streaming bundle of the converter: FP16 word in, fixed-point result
// plus status flags out, each side with its own valid/ready pair.
interface fp16_to_fixed_pipe_if #(
  parameter int OUT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;
  logic             out_nan;
  logic             out_inexact;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_nan, out_inexact
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_nan, out_inexact
  );

endinterface

// File: rtl/fp16_decode.sv
// Combinational FP16 classifier: splits the word into sign, 11-bit significand and
// the signed shift that aligns the significand to the output binary point.
module fp16_decode
  import fp16_pkg::*;
#(
  parameter int FRAC_W = 0
) (
  input  logic [15:0]               in_data,
  output fp16_class_t               cls,
  output logic                      sign,
  output logic [SIG_W-1:0]          sig,
  output logic signed [SHIFT_W-1:0] shift
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic [EXP_W-1:0] exp_eff;

  always_comb begin
    sign    = in_data[15];
    exp_f   = in_data[14:10];
    man_f   = in_data[9:0];
    // Subnormals share the scale of exponent 1, only without the hidden bit.
    exp_eff = (exp_f == '0) ? EXP_W'(1) : exp_f;
    sig     = {exp_f != '0, man_f};
    shift   = SHIFT_W'(int'(exp_eff) - EXP_BIAS - MAN_W + FRAC_W);
    if (exp_f == EXP_W'(EXP_MAX)) begin
      cls = (man_f != '0) ? NAN : INF;
      sig = '0;
    end else if (exp_f == '0) begin
      cls = (man_f == '0) ? ZERO : SUBNORM;
    end else begin
      cls = NORMAL;
    end
  end

endmodule

// File: rtl/fp16_to_fixed_pipe.sv
// Three-stage FP16 to signed fixed-point converter with rounding, saturation,
// status flags, global-stall flow control and a saturation event counter.
module fp16_to_fixed_pipe
  import fp16_pkg::*;
#(
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 0,
  parameter int ROUND  = 0
) (
  input  logic                clk,
  input  logic                rst,
  fp16_to_fixed_pipe_if.slave bus,
  input  logic                clr_cnt,
  output logic [15:0]         sat_cnt
);

  // 24 fraction bits hold the deepest right shift (smallest subnormal, FRAC_W=0);
  // 48 integer bits hold the widest left shift (largest normal, FRAC_W=30).
  localparam int FRAC_X = 24;
  localparam int MAG_W  = 48;
  localparam int EXT_W  = MAG_W + FRAC_X;
  localparam logic [MAG_W-1:0] POS_LIM = (MAG_W'(1) << (OUT_W - 1)) - MAG_W'(1);
  localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(1) << (OUT_W - 1);

  function automatic logic [MAG_W-1:0] round_mag(input logic [MAG_W-1:0] mag,
                                                 input logic guard);
    return (ROUND != 0 && guard) ? mag + MAG_W'(1) : mag;
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic sign,
                                                       input logic ovf,
                                                       input logic nan,
                                                       input logic [OUT_W-1:0] mag);
    logic signed [OUT_W-1:0] max_v;
    max_v = {1'b0, {(OUT_W - 1){1'b1}}};
    if (nan) return '0;
    if (ovf) return sign ? ~max_v : max_v;
    return sign ? -$signed(mag) : $signed(mag);
  endfunction

  logic stall;
  assign stall        = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  // S1: decode and classify
  fp16_class_t               cls_s1;
  logic                      sign_s1;
  logic [SIG_W-1:0]          sig_s1;
  logic signed [SHIFT_W-1:0] shift_s1;

  fp16_decode #(.FRAC_W(FRAC_W)) u_decode (
    .in_data (bus.in_data),
    .cls     (cls_s1),
    .sign    (sign_s1),
    .sig     (sig_s1),
    .shift   (shift_s1)
  );

  logic                      vld_p0;
  fp16_class_t               cls_p0;
  logic                      sign_p0;
  logic [SIG_W-1:0]          sig_p0;
  logic signed [SHIFT_W-1:0] shift_p0;

  // S2: barrel shift, guard/sticky, rounding, overflow detection
  logic [EXT_W-1:0]   base_s2;
  logic [SHIFT_W-1:0] amt_s2;
  logic [EXT_W-1:0]   ext_s2;
  logic [MAG_W-1:0]   mag_raw_s2;
  logic [FRAC_X-1:0]  frac_s2;
  logic [MAG_W-1:0]   mag_s2;
  logic               ovf_s2;
  logic               nan_s2;
  logic               inexact_s2;

  always_comb begin
    base_s2    = EXT_W'(sig_p0) << FRAC_X;
    amt_s2     = shift_p0[SHIFT_W-1] ? SHIFT_W'(-shift_p0) : SHIFT_W'(shift_p0);
    ext_s2     = shift_p0[SHIFT_W-1] ? (base_s2 >> amt_s2) : (base_s2 << amt_s2);
    mag_raw_s2 = ext_s2[EXT_W-1:FRAC_X];
    frac_s2    = ext_s2[FRAC_X-1:0];
    mag_s2     = round_mag(mag_raw_s2, frac_s2[FRAC_X-1]);
    // The negative bound is one larger in magnitude than the positive one.
    ovf_s2     = mag_s2 > (sign_p0 ? NEG_LIM : POS_LIM);
    nan_s2     = 1'b0;
    case (cls_p0)
      INF: ovf_s2 = 1'b1;
      NAN: begin
        ovf_s2 = 1'b0;
        nan_s2 = 1'b1;
      end
      default: ;
    endcase
    inexact_s2 = (|frac_s2) & ~ovf_s2 & ~nan_s2;
  end

  logic             vld_p1;
  logic             sign_p1;
  logic [OUT_W-1:0] mag_p1;
  logic             ovf_p1;
  logic             nan_p1;
  logic             inexact_p1;

  always_ff @(posedge clk) begin
    if (!stall) begin
      cls_p0     <= cls_s1;
      sign_p0    <= sign_s1;
      sig_p0     <= sig_s1;
      shift_p0   <= shift_s1;
      sign_p1    <= sign_p0;
      mag_p1     <= mag_s2[OUT_W-1:0];
      ovf_p1     <= ovf_s2;
      nan_p1     <= nan_s2;
      inexact_p1 <= inexact_s2;
    end
  end

  // S3: negation, saturation, flag assembly into the registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0          <= 1'b0;
      vld_p1          <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_ovf     <= 1'b0;
      bus.out_nan     <= 1'b0;
      bus.out_inexact <= 1'b0;
    end else if (!stall) begin
      vld_p0        <= bus.in_valid;
      vld_p1        <= vld_p0;
      bus.out_valid <= vld_p1;
      if (vld_p1) begin
        bus.out_data    <= saturate(sign_p1, ovf_p1, nan_p1, mag_p1);
        bus.out_ovf     <= ovf_p1;
        bus.out_nan     <= nan_p1;
        bus.out_inexact <= inexact_p1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (clr_cnt) begin
      sat_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready && bus.out_ovf && sat_cnt != 16'hFFFF) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fp16_to_fixed_pipe.sv
// Directed bench for fp16_to_fixed_pipe: three instances (truncate, round-nearest,
// FRAC_W=8) driven in lockstep from a hand-computed vector table.
module tb_fp16_to_fixed_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_cnt;
  logic [15:0] sat0, sat1, sat2;

  always #5 clk = ~clk;

  fp16_to_fixed_pipe_if #(.OUT_W(16)) b0 ();
  fp16_to_fixed_pipe_if #(.OUT_W(16)) b1 ();
  fp16_to_fixed_pipe_if #(.OUT_W(16)) b2 ();

  fp16_to_fixed_pipe #(.OUT_W(16), .FRAC_W(0), .ROUND(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0), .clr_cnt(clr_cnt), .sat_cnt(sat0));
  fp16_to_fixed_pipe #(.OUT_W(16), .FRAC_W(0), .ROUND(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .clr_cnt(clr_cnt), .sat_cnt(sat1));
  fp16_to_fixed_pipe #(.OUT_W(16), .FRAC_W(8), .ROUND(0)) dut2 (
    .clk(clk), .rst(rst), .bus(b2), .clr_cnt(clr_cnt), .sat_cnt(sat2));

  // flags packed as {ovf, nan, inexact}
  typedef struct {
    logic [15:0] din;
    logic [15:0] e0; logic [2:0] f0;
    logic [15:0] e1; logic [2:0] f1;
    logic [15:0] e2; logic [2:0] f2;
  } vec_t;

  vec_t tv[18];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [15:0] d);
    b0.in_valid = v; b1.in_valid = v; b2.in_valid = v;
    b0.in_data  = d; b1.in_data  = d; b2.in_data  = d;
  endtask

  task automatic set_rdy(input logic r);
    b0.out_ready = r; b1.out_ready = r; b2.out_ready = r;
  endtask

  // One isolated word: checks 3-cycle latency and all three results.
  task automatic run_vec(input int i);
    int lat;
    lat = 0;
    @(negedge clk);
    set_in(1'b1, tv[i].din);
    @(posedge clk);
    #1;
    set_in(1'b0, 16'hFFFF);
    for (int n = 1; n <= 6; n++) begin
      if (b0.out_valid) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk($sformatf("lat[%0d]", i), lat, 3);
    chk($sformatf("d0[%0d]", i), b0.out_data, tv[i].e0);
    chk($sformatf("f0[%0d]", i), {b0.out_ovf, b0.out_nan, b0.out_inexact}, tv[i].f0);
    chk($sformatf("d1[%0d]", i), b1.out_data, tv[i].e1);
    chk($sformatf("f1[%0d]", i), {b1.out_ovf, b1.out_nan, b1.out_inexact}, tv[i].f1);
    chk($sformatf("d2[%0d]", i), b2.out_data, tv[i].e2);
    chk($sformatf("f2[%0d]", i), {b2.out_ovf, b2.out_nan, b2.out_inexact}, tv[i].f2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ii, oi, stale, extra;
    logic hold_v, rdy, exp_rdy;
    logic [15:0] held;

    tv[0]  = '{16'h4500, 16'h0005, 3'b000, 16'h0005, 3'b000, 16'h0500, 3'b000};
    tv[1]  = '{16'hC500, 16'hFFFB, 3'b000, 16'hFFFB, 3'b000, 16'hFB00, 3'b000};
    tv[2]  = '{16'h0000, 16'h0000, 3'b000, 16'h0000, 3'b000, 16'h0000, 3'b000};
    tv[3]  = '{16'h8000, 16'h0000, 3'b000, 16'h0000, 3'b000, 16'h0000, 3'b000};
    tv[4]  = '{16'h3E00, 16'h0001, 3'b001, 16'h0002, 3'b001, 16'h0180, 3'b000};
    tv[5]  = '{16'h4100, 16'h0002, 3'b001, 16'h0003, 3'b001, 16'h0280, 3'b000};
    tv[6]  = '{16'h7800, 16'h7FFF, 3'b100, 16'h7FFF, 3'b100, 16'h7FFF, 3'b100};
    tv[7]  = '{16'h7BFF, 16'h7FFF, 3'b100, 16'h7FFF, 3'b100, 16'h7FFF, 3'b100};
    tv[8]  = '{16'h7C00, 16'h7FFF, 3'b100, 16'h7FFF, 3'b100, 16'h7FFF, 3'b100};
    tv[9]  = '{16'hF800, 16'h8000, 3'b000, 16'h8000, 3'b000, 16'h8000, 3'b100};
    tv[10] = '{16'hFC00, 16'h8000, 3'b100, 16'h8000, 3'b100, 16'h8000, 3'b100};
    tv[11] = '{16'h7E00, 16'h0000, 3'b010, 16'h0000, 3'b010, 16'h0000, 3'b010};
    tv[12] = '{16'h0001, 16'h0000, 3'b001, 16'h0000, 3'b001, 16'h0000, 3'b001};
    tv[13] = '{16'h5BFF, 16'h00FF, 3'b001, 16'h0100, 3'b001, 16'h7FFF, 3'b100};
    tv[14] = '{16'hBC00, 16'hFFFF, 3'b000, 16'hFFFF, 3'b000, 16'hFF00, 3'b000};
    tv[15] = '{16'hBE00, 16'hFFFF, 3'b001, 16'hFFFE, 3'b001, 16'hFE80, 3'b000};
    tv[16] = '{16'h3800, 16'h0000, 3'b001, 16'h0001, 3'b001, 16'h0080, 3'b000};
    tv[17] = '{16'hB800, 16'h0000, 3'b001, 16'hFFFF, 3'b001, 16'hFF80, 3'b000};

    rst = 1'b1;
    clr_cnt = 1'b0;
    set_in(1'b0, 16'h0000);
    set_rdy(1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", b0.out_valid, 0);
    chk("rst_data", b0.out_data, 0);
    chk("rst_flags", {b0.out_ovf, b0.out_nan, b0.out_inexact}, 0);
    chk("rst_sat", sat0, 0);
    chk("rst_in_ready", b0.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) run_vec(i);
    @(posedge clk);
    #1;
    chk("sat_cnt0", sat0, 4);
    chk("sat_cnt1", sat1, 4);
    chk("sat_cnt2", sat2, 6);

    // Backpressure stream of tv[0..9] with random out_ready
    ii = 0; oi = 0; hold_v = 1'b0; held = '0;
    for (int cyc = 0; cyc < 400 && oi < 10; cyc++) begin
      @(negedge clk);
      rdy = 1'($urandom_range(0, 1));
      set_rdy(rdy);
      if (ii < 10) set_in(1'b1, tv[ii].din);
      else         set_in(1'b0, 16'h7E00);
      #1;
      exp_rdy = ~(b0.out_valid & ~b0.out_ready);
      chk("bp_in_ready", b0.in_ready, exp_rdy);
      if (hold_v) begin
        chk("bp_stall_vld", b0.out_valid, 1);
        chk("bp_stable", b0.out_data, held);
      end
      if (b0.in_valid && b0.in_ready) ii++;
      if (b0.out_valid && b0.out_ready) begin
        chk($sformatf("bp_d[%0d]", oi), b0.out_data, tv[oi].e0);
        chk($sformatf("bp_f[%0d]", oi), {b0.out_ovf, b0.out_nan, b0.out_inexact}, tv[oi].f0);
        oi++;
      end
      hold_v = b0.out_valid & ~b0.out_ready;
      held   = b0.out_data;
    end
    chk("bp_count", oi, 10);
    set_rdy(1'b1);
    set_in(1'b0, 16'h0000);
    extra = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (b0.out_valid) extra++;
    end
    chk("bp_extra", extra, 0);

    // Reset with three words in flight
    @(negedge clk);
    set_in(1'b1, 16'h7C00);
    repeat (3) @(posedge clk);
    #1;
    set_in(1'b0, 16'h0000);
    chk("pre_rst_vld", b0.out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", b0.out_valid, 0);
    chk("mid_rst_data", b0.out_data, 0);
    chk("mid_rst_flags", {b0.out_ovf, b0.out_nan, b0.out_inexact}, 0);
    chk("mid_rst_sat", sat0, 0);
    chk("mid_rst_in_ready", b0.in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (b0.out_valid || b1.out_valid || b2.out_valid) stale++;
    end
    chk("no_stale", stale, 0);

    // Counter increment, then clear coinciding with a saturated handshake
    run_vec(8);
    @(posedge clk);
    #1;
    chk("sat_after_inf", sat0, 1);
    run_vec(8);
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    chk("clr_wins0", sat0, 0);
    chk("clr_wins1", sat1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
